// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard/stall controller.
// Holds the controller state encoding and the data-memory wait counter width.
// No logic here; imported by the controller and its hazard detector.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2
  } state_e;

  localparam int unsigned DWAIT_CNT_W = 16;
  typedef logic [DWAIT_CNT_W-1:0] dwait_cnt_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID-stage sources and the EX-stage load.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is consumed by the pipeline controller.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       hazard
);

  // x0 never carries a real result, so a load targeting it creates no hazard
  always_comb begin
    hazard = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
              (id_uses_rs2 && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline register controller: freezes, redirects, bubbles and counts stalls.
// Latency: control outputs are combinational; state/counters update next edge.
// Backpressure: dmem wait freezes the whole pipe, fetch wait inserts NOPs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
  output logic        dmem_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  state_e      state_q, state_d;
  dwait_cnt_t  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic        lu_done_q, lu_done_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        lu_hazard;
  logic        dmem_stall;
  logic        lu_stall;

  load_use_detect u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .hazard      (lu_hazard)
  );

  // A load-use hazard gets exactly one bubble: the cycle after a load-use
  // stall the same hazard indication is ignored.
  always_comb begin
    dmem_stall = dmem_req & ~dmem_ready;
    lu_stall   = lu_hazard & ~lu_done_q;
  end

  // Priority resolution, next-state, wait/timeout and perf counter updates
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_d     = timeout_q;
    lu_done_d     = lu_done_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      state_d     = ST_RUN;
      wait_cnt_d  = '0;
      timeout_d   = 1'b0;
      lu_done_d   = 1'b0;
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else if (dmem_stall) begin
      // Full freeze; only a bubble drains into WB. Counter saturates so a
      // very long wait can never wrap back below the timeout threshold.
      mem_wb_bubble = 1'b1;
      state_d       = ST_DWAIT;
      if (wait_cnt_q != '1) begin
        wait_cnt_d = wait_cnt_q + dwait_cnt_t'(1);
      end
      if (wait_cnt_d == dwait_cnt_t'(DMEM_TIMEOUT)) begin
        timeout_d = 1'b1;
      end
    end else begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      state_d      = imem_ready ? ST_RUN : ST_IWAIT;
      lu_done_d    = 1'b0;
      if (state_q == ST_DWAIT) begin
        wait_cnt_d = '0;
      end
      if (ex_branch_taken) begin
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (lu_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        lu_done_d   = 1'b1;
      end else if (!imem_ready) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b1;
      end
    end

    if (!rst && !pc_write) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State and counter registers; reset is folded into the _d logic
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    timeout_q   <= timeout_d;
    lu_done_q   <= lu_done_d;
    stall_cnt_q <= stall_cnt_d;
    flush_cnt_q <= flush_cnt_d;
  end

  assign dmem_timeout = timeout_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random stimulus
// compared against an event-level reference model of the stall/flush rules.
// Timeout parameter is shrunk so the wait-limit behaviour is reachable.
module tb_pipe_ctrl;

  localparam int T = 4;

  // Control vector order: pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, bubble
  localparam logic [6:0] C_RST    = 7'b0000000;
  localparam logic [6:0] C_NORMAL = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_REDIR  = 7'b1011110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_FETCH  = 7'b0011010;

  localparam int EV_RST = 0, EV_DMEM = 1, EV_REDIR = 2, EV_LU = 3, EV_FETCH = 4, EV_NORM = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
  logic        ex_branch_taken, imem_ready, dmem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic        ex_mem_write, mem_wb_bubble, dmem_timeout;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctrl;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_wait     = 0;
  bit          m_timeout  = 1'b0;
  bit          m_lu_prev  = 1'b0;
  logic [31:0] m_stall    = '0;
  logic [31:0] m_flush    = '0;

  pipe_ctrl #(.DMEM_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_bubble(mem_wb_bubble),
    .dmem_timeout(dmem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                 ex_mem_write, mem_wb_bubble};

  always #5 clk = ~clk;

  // Which rule wins this cycle, judged from the current inputs
  function automatic int cur_event();
    bit hz;
    hz = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    if (rst) return EV_RST;
    if (dmem_req && !dmem_ready) return EV_DMEM;
    if (ex_branch_taken) return EV_REDIR;
    if (hz && !m_lu_prev) return EV_LU;
    if (!imem_ready) return EV_FETCH;
    return EV_NORM;
  endfunction

  function automatic logic [6:0] ev_ctrl(input int ev);
    case (ev)
      EV_RST:   return C_RST;
      EV_DMEM:  return C_FREEZE;
      EV_REDIR: return C_REDIR;
      EV_LU:    return C_LU;
      EV_FETCH: return C_FETCH;
      default:  return C_NORMAL;
    endcase
  endfunction

  task automatic model_update();
    int ev;
    ev = cur_event();
    if (ev == EV_RST) begin
      m_wait = 0; m_timeout = 1'b0; m_lu_prev = 1'b0; m_stall = '0; m_flush = '0;
    end else if (ev == EV_DMEM) begin
      if (m_wait < 65535) m_wait = m_wait + 1;
      if (m_wait == T) m_timeout = 1'b1;
      m_stall = m_stall + 32'd1;
    end else begin
      m_wait    = 0;
      m_lu_prev = (ev == EV_LU);
      if (ev == EV_REDIR) m_flush = m_flush + 32'd1;
      if (ev == EV_LU || ev == EV_FETCH) m_stall = m_stall + 32'd1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 5'd0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== C_RST) begin errors++; $display("FAIL reset_ctrl got %b exp %b", ctrl, C_RST); end
    tick(); tick();
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
    checks++; if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", dmem_timeout); end
    rst = 1'b0;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL post_reset_ctrl got %b exp %b", ctrl, C_NORMAL); end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    #1;
    checks++; if (ctrl !== C_LU) begin errors++; $display("FAIL lu_ctrl got %b exp %b", ctrl, C_LU); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL lu_stall_before got %0d exp 0", stall_cnt); end
    tick();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_after got %0d exp 1", stall_cnt); end
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL lu_release got %b exp %b", ctrl, C_NORMAL); end
    tick();
  endtask

  task automatic test_redirect_iwait();
    ex_branch_taken = 1'b1; imem_ready = 1'b0;
    #1;
    checks++; if (ctrl !== C_REDIR) begin errors++; $display("FAIL redir_ctrl got %b exp %b", ctrl, C_REDIR); end
    tick();
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL redir_flush_cnt got %0d exp 1", flush_cnt); end
    ex_branch_taken = 1'b0; imem_ready = 1'b0;
    #1;
    checks++; if (ctrl !== C_FETCH) begin errors++; $display("FAIL iwait_ctrl got %b exp %b", ctrl, C_FETCH); end
    tick();
    imem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL iwait_exit got %b exp %b", ctrl, C_NORMAL); end
    checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL iwait_stall_cnt got %0d exp 2", stall_cnt); end
    tick();
  endtask

  task automatic test_dmem_timeout();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL dwait_ctrl cyc %0d got %b exp %b", i, ctrl, C_FREEZE); end
      checks++; if (dmem_timeout !== (i >= 5)) begin errors++; $display("FAIL dwait_timeout cyc %0d got %b exp %b", i, dmem_timeout, (i >= 5)); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL dwait_exit got %b exp %b", ctrl, C_NORMAL); end
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++; if (dmem_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got %b exp 1", dmem_timeout); end
    checks++; if (stall_cnt !== 32'd8) begin errors++; $display("FAIL dwait_stall_cnt got %0d exp 8", stall_cnt); end
  endtask

  task automatic test_dmem_priority();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL prio_ctrl cyc %0d got %b exp %b", i, ctrl, C_FREEZE); end
      tick();
      checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL prio_flush_hold cyc %0d got %0d exp 1", i, flush_cnt); end
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_REDIR) begin errors++; $display("FAIL prio_redirect got %b exp %b", ctrl, C_REDIR); end
    tick();
    checks++; if (flush_cnt !== 32'd2) begin errors++; $display("FAIL prio_flush_cnt got %0d exp 2", flush_cnt); end
    idle_inputs();
  endtask

  task automatic test_x0_and_rst();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL x0_no_stall got %b exp %b", ctrl, C_NORMAL); end
    tick();
    idle_inputs();
    dmem_req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    checks++; if (ctrl !== C_RST) begin errors++; $display("FAIL rst_in_dwait got %b exp %b", ctrl, C_RST); end
    tick();
    rst = 1'b0; dmem_req = 1'b0;
    #1;
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL rst_run got %b exp %b", ctrl, C_NORMAL); end
    checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++; $display("FAIL rst_counters got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    checks++; if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", dmem_timeout); end
    dmem_req = 1'b1;
    for (int i = 0; i < T - 1; i++) tick();
    dmem_req = 1'b0;
    #1;
    checks++; if (dmem_timeout !== 1'b0) begin errors++; $display("FAIL wait_cnt_cleared got %b exp 0", dmem_timeout); end
    checks++; if (stall_cnt !== 32'(T - 1)) begin errors++; $display("FAIL rst_restall_cnt got %0d exp %0d", stall_cnt, T - 1); end
    tick();
  endtask

  task automatic test_random();
    logic [6:0] exp;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst             = ($urandom_range(0, 79) == 0);
      dmem_req        = ($urandom_range(0, 2) == 0);
      dmem_ready      = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read     = $urandom_range(0, 1);
      ex_rd           = 5'($urandom_range(0, 3));
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_uses_rs1     = $urandom_range(0, 1);
      id_uses_rs2     = $urandom_range(0, 1);
      imem_ready      = ($urandom_range(0, 3) != 0);
      #1;
      exp = ev_ctrl(cur_event());
      checks++; if (ctrl !== exp) begin errors++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", cyc, ctrl, exp); end
      checks++; if (if_id_write === 1'b1 && if_id_flush === 1'b1) begin errors++; $display("FAIL rand_ifid_excl cyc %0d got both 1 exp not both", cyc); end
      checks++; if (stall_cnt !== m_stall) begin errors++; $display("FAIL rand_stall_cnt cyc %0d got %0d exp %0d", cyc, stall_cnt, m_stall); end
      checks++; if (flush_cnt !== m_flush) begin errors++; $display("FAIL rand_flush_cnt cyc %0d got %0d exp %0d", cyc, flush_cnt, m_flush); end
      checks++; if (dmem_timeout !== m_timeout) begin errors++; $display("FAIL rand_timeout cyc %0d got %b exp %b", cyc, dmem_timeout, m_timeout); end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_redirect_iwait();
    test_dmem_timeout();
    test_dmem_priority();
    test_x0_and_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
